// File: rtl/symbol_drawer_if.sv
// symbol_drawer_if: bundles the start/ready request, the font ROM port and
// the framebuffer pixel-write channel of the symbol drawer.
// The slave modport is the drawer's view; the master modport is the
// surrounding system (sequencer, font ROM, framebuffer writer).
interface symbol_drawer_if #(
  parameter int SYMBOL_WIDTH      = 7,
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int GLYPH_COLS        = 5
);
  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);

  // request handshake
  logic                    start;
  logic                    ready;
  logic [SYMBOL_WIDTH-1:0] symbol;
  logic [X_WIDTH-1:0]      x;
  logic [Y_WIDTH-1:0]      y;

  // font ROM port
  logic [SYMBOL_WIDTH+2:0] font_addr;
  logic [GLYPH_COLS-1:0]   font_data;

  // framebuffer write channel
  logic                    fb_wr_valid;
  logic                    fb_wr_ready;
  logic [X_WIDTH-1:0]      fb_wr_x;
  logic [Y_WIDTH-1:0]      fb_wr_y;
  logic                    fb_wr_data;

  modport slave (
    input  start, symbol, x, y, font_data, fb_wr_ready,
    output ready, font_addr, fb_wr_valid, fb_wr_x, fb_wr_y, fb_wr_data
  );

  modport master (
    output start, symbol, x, y, font_data, fb_wr_ready,
    input  ready, font_addr, fb_wr_valid, fb_wr_x, fb_wr_y, fb_wr_data
  );
endinterface

// File: rtl/symbol_drawer.sv
// symbol_drawer: on a start pulse, latches a symbol code and a top-left
// position, reads the glyph row by row from a synchronous font ROM and
// emits SCALE x SCALE replicated pixel writes over a valid/ready channel.
// Pixels outside the visible area are skipped without a write.
// Optional feature macro: SYMBOL_DRAWER_TRANSPARENT_EN -- when defined only
// foreground pixels are written (data always 1); when undefined every
// visible pixel of the glyph cell is written with its font bit.
module symbol_drawer #(
  parameter int SYMBOL_WIDTH      = 7,
  parameter int HOR_ACTIVE_PIXELS = 640,
  parameter int VER_ACTIVE_PIXELS = 480,
  parameter int GLYPH_COLS        = 5,
  parameter int GLYPH_ROWS        = 7,
  parameter int SCALE             = 2
) (
  input logic           clk,
  input logic           rst,
  symbol_drawer_if.slave bus
);

  localparam int X_WIDTH = $clog2(HOR_ACTIVE_PIXELS);
  localparam int Y_WIDTH = $clog2(VER_ACTIVE_PIXELS);
  localparam int CW      = (GLYPH_COLS > 1) ? $clog2(GLYPH_COLS) : 1;
  localparam int SW      = (SCALE > 1) ? $clog2(SCALE) : 1;

  localparam logic [SW-1:0]    SUB_LAST = SW'(SCALE - 1);
  localparam logic [CW-1:0]    COL_LAST = CW'(GLYPH_COLS - 1);
  localparam logic [2:0]       ROW_LAST = 3'(GLYPH_ROWS - 1);
  localparam logic [X_WIDTH:0] X_LIMIT  = (X_WIDTH + 1)'(HOR_ACTIVE_PIXELS);
  localparam logic [Y_WIDTH:0] Y_LIMIT  = (Y_WIDTH + 1)'(VER_ACTIVE_PIXELS);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    DRAW,
    FINISH
  } state_t;

  state_t                  state_q;
  logic [SYMBOL_WIDTH-1:0] symbol_q;
  logic [X_WIDTH-1:0]      x_q;
  logic [Y_WIDTH-1:0]      y_q;
  logic [2:0]              row_q;
  logic [SW-1:0]           sy_q;
  logic [CW-1:0]           col_q;
  logic [SW-1:0]           sx_q;
  logic [GLYPH_COLS-1:0]   bits_q;

  logic                    ready_q;
  logic [SYMBOL_WIDTH+2:0] font_addr_q;
  logic                    valid_q;
  logic [X_WIDTH-1:0]      wr_x_q;
  logic [Y_WIDTH-1:0]      wr_y_q;
  logic                    wr_data_q;

  // step counters for the pixel following the one currently presented
  logic [SW-1:0]           nxt_sx;
  logic [CW-1:0]           nxt_col;
  logic [SW-1:0]           nxt_sy;
  logic                    last_px;

  // candidate pixel that will be presented on the next clock edge
  logic [SW-1:0]           t_sx;
  logic [CW-1:0]           t_col;
  logic [SW-1:0]           t_sy;
  logic [GLYPH_COLS-1:0]   t_bits;
  logic [GLYPH_COLS-1:0]   shifted;
  logic [X_WIDTH-1:0]      px_x;
  logic [Y_WIDTH-1:0]      px_y;
  logic                    px_bit;
  logic                    px_vis;
  logic                    px_valid;
  logic                    px_data;

  assign bus.ready       = ready_q;
  assign bus.font_addr   = font_addr_q;
  assign bus.fb_wr_valid = valid_q;
  assign bus.fb_wr_x     = wr_x_q;
  assign bus.fb_wr_y     = wr_y_q;
  assign bus.fb_wr_data  = wr_data_q;

  // Advance sub-column, column, sub-row (inner to outer) within one glyph row.
  always_comb begin
    nxt_sx  = sx_q + SW'(1);
    nxt_col = col_q;
    nxt_sy  = sy_q;
    last_px = 1'b0;
    if (sx_q == SUB_LAST) begin
      nxt_sx  = '0;
      nxt_col = col_q + CW'(1);
      if (col_q == COL_LAST) begin
        nxt_col = '0;
        nxt_sy  = sy_q + SW'(1);
        if (sy_q == SUB_LAST) begin
          nxt_sy  = '0;
          last_px = 1'b1;
        end
      end
    end
  end

  // Pixel coordinates, colour and write-enable for the next presented step.
  // In LOAD the first pixel of the row is formed straight from the ROM data
  // so that DRAW starts with a registered pixel already on the outputs.
  always_comb begin
    if (state_q == LOAD) begin
      t_sx   = '0;
      t_col  = '0;
      t_sy   = '0;
      t_bits = bus.font_data;
    end else begin
      t_sx   = nxt_sx;
      t_col  = nxt_col;
      t_sy   = nxt_sy;
      t_bits = bits_q;
    end
    px_x    = x_q + X_WIDTH'(t_col) * X_WIDTH'(SCALE) + X_WIDTH'(t_sx);
    px_y    = y_q + Y_WIDTH'(row_q) * Y_WIDTH'(SCALE) + Y_WIDTH'(t_sy);
    shifted = t_bits << t_col;
    px_bit  = shifted[GLYPH_COLS-1];
    px_vis  = ({1'b0, px_x} < X_LIMIT) && ({1'b0, px_y} < Y_LIMIT);
`ifdef SYMBOL_DRAWER_TRANSPARENT_EN
    px_valid = px_vis & px_bit;
    px_data  = 1'b1;
`else
    px_valid = px_vis;
    px_data  = px_bit;
`endif
  end

  // Control FSM with registered handshake, ROM address and pixel outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      symbol_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      row_q       <= '0;
      sy_q        <= '0;
      col_q       <= '0;
      sx_q        <= '0;
      bits_q      <= '0;
      ready_q     <= 1'b1;
      font_addr_q <= '0;
      valid_q     <= 1'b0;
      wr_x_q      <= '0;
      wr_y_q      <= '0;
      wr_data_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            symbol_q <= bus.symbol;
            x_q      <= bus.x;
            y_q      <= bus.y;
            row_q    <= '0;
            sy_q     <= '0;
            col_q    <= '0;
            sx_q     <= '0;
            ready_q  <= 1'b0;
            if (bus.symbol == '0) begin
              state_q <= FINISH;
            end else begin
              font_addr_q <= {bus.symbol, 3'b000};
              state_q     <= FETCH;
            end
          end
        end
        FETCH: begin
          state_q <= LOAD;
        end
        LOAD: begin
          bits_q    <= bus.font_data;
          valid_q   <= px_valid;
          wr_x_q    <= px_x;
          wr_y_q    <= px_y;
          wr_data_q <= px_data;
          state_q   <= DRAW;
        end
        DRAW: begin
          // a skipped step never waits; a real write waits for acceptance
          if (!valid_q || bus.fb_wr_ready) begin
            if (last_px) begin
              valid_q <= 1'b0;
              sx_q    <= '0;
              col_q   <= '0;
              sy_q    <= '0;
              if (row_q == ROW_LAST) begin
                state_q <= FINISH;
              end else begin
                row_q       <= row_q + 3'd1;
                font_addr_q <= {symbol_q, row_q + 3'd1};
                state_q     <= FETCH;
              end
            end else begin
              sx_q      <= nxt_sx;
              col_q     <= nxt_col;
              sy_q      <= nxt_sy;
              valid_q   <= px_valid;
              wr_x_q    <= px_x;
              wr_y_q    <= px_y;
              wr_data_q <= px_data;
            end
          end
        end
        FINISH: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_drawer.sv
// tb_symbol_drawer: table-driven bench for symbol_drawer with a scoreboard
// of expected pixel writes, a synchronous font ROM model and
// selectable framebuffer backpressure patterns.
module tb_symbol_drawer;

  localparam int SC     = 2;
  localparam int G_COLS = 5;
  localparam int G_ROWS = 7;
  localparam int FULL_LAT = G_ROWS * (2 + G_COLS * SC * SC) + 1;

  typedef struct {
    logic [6:0] sym;
    int         x;
    int         y;
    int         mode;   // 0 ready high, 1 toggling, 2 random, 3 held low
    bit         dup;    // extra start pulse mid-glyph
    int         lat;    // ready-low cycles without stalls
    int         nwr;    // accepted writes
  } vec_t;

  logic clk;
  logic rst;
  symbol_drawer_if bus ();

  symbol_drawer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [19:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int stall_mode = 0;
  bit tog = 1'b0;
  int busy_cnt = 0;
  int stall_cnt = 0;
  int wr_cnt = 0;
  bit hold_pending = 1'b0;
  logic [20:0] held_word = '0;
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] rom_fn(input logic [9:0] a);
    logic [6:0] s;
    logic [2:0] r;
    s = a[9:3];
    r = a[2:0];
    case (s)
      7'd1:    rom_fn = 5'b10001;
      7'd2:    rom_fn = 5'b11111;
      default: rom_fn = 5'(int'(s) * 3 + int'(r) * 7 + 1);
    endcase
  endfunction

  // synchronous font ROM: data one cycle after address
  always @(posedge clk) bus.font_data <= rom_fn(bus.font_addr);

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_push(input logic [6:0] sym, input int x0, input int y0);
    for (int r = 0; r < G_ROWS; r++)
      for (int sy = 0; sy < SC; sy++)
        for (int c = 0; c < G_COLS; c++)
          for (int sx = 0; sx < SC; sx++) begin
            logic [4:0] bits;
            logic [9:0] px;
            logic [8:0] py;
            bits = rom_fn({sym, 3'(r)});
            px = 10'(x0 + c * SC + sx);
            py = 9'(y0 + r * SC + sy);
            if (px < 640 && py < 480)
`ifdef SYMBOL_DRAWER_TRANSPARENT_EN
              if (bits[4-c]) exp_q.push_back({px, py, 1'b1});
`else
              exp_q.push_back({px, py, bits[4-c]});
`endif
          end
  endtask

  // one clock: drive fb_wr_ready for the coming edge, then observe outputs
  task automatic step();
    @(negedge clk);
    case (stall_mode)
      0: bus.fb_wr_ready = 1'b1;
      1: begin tog = ~tog; bus.fb_wr_ready = tog; end
      2: bus.fb_wr_ready = 1'($urandom_range(0, 1));
      default: bus.fb_wr_ready = 1'b0;
    endcase
    if (!bus.ready) busy_cnt++;
    if (hold_pending)
      chk("stall_hold", int'({bus.fb_wr_valid, bus.fb_wr_x, bus.fb_wr_y, bus.fb_wr_data}),
          int'(held_word));
    hold_pending = bus.fb_wr_valid && !bus.fb_wr_ready;
    held_word = {bus.fb_wr_valid, bus.fb_wr_x, bus.fb_wr_y, bus.fb_wr_data};
    if (hold_pending) stall_cnt++;
    if (bus.fb_wr_valid && bus.fb_wr_ready) begin
      wr_cnt++;
      if (exp_q.size() == 0) chk("write_queue_nonempty", exp_q.size(), 1);
      else chk("wr_pixel", int'({bus.fb_wr_x, bus.fb_wr_y, bus.fb_wr_data}),
               int'(exp_q.pop_front()));
    end
  endtask

  task automatic run_vec(input vec_t v);
    int b0, s0, w0, n;
    stall_mode = v.mode;
    if (v.sym != 0) model_push(v.sym, v.x, v.y);
    b0 = busy_cnt;
    s0 = stall_cnt;
    w0 = wr_cnt;
    bus.symbol = v.sym;
    bus.x = 10'(v.x);
    bus.y = 9'(v.y);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("ready_fall", bus.ready, 0);
    n = 0;
    while (!bus.ready && n < 2000) begin
      if (v.dup && n == 40) begin
        bus.symbol = 7'd2;
        bus.x = 10'd300;
        bus.y = 9'd17;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      step();
      n++;
    end
    bus.start = 1'b0;
    chk("done_in_budget", bus.ready, 1);
    chk("latency", busy_cnt - b0, v.lat + (stall_cnt - s0));
    chk("write_count", wr_cnt - w0, v.nwr);
    chk("queue_drained", exp_q.size(), 0);
    exp_q.delete();
    stall_mode = 0;
    repeat (2) step();
  endtask

  initial begin
    int n;
    vecs[0] = '{sym: 7'd1,   x: 0,   y: 460, mode: 0, dup: 1'b0, lat: FULL_LAT, nwr: 140};
    vecs[1] = '{sym: 7'd0,   x: 0,   y: 0,   mode: 0, dup: 1'b0, lat: 1,        nwr: 0};
    vecs[2] = '{sym: 7'd1,   x: 0,   y: 460, mode: 1, dup: 1'b0, lat: FULL_LAT, nwr: 140};
    vecs[3] = '{sym: 7'd2,   x: 635, y: 475, mode: 0, dup: 1'b0, lat: FULL_LAT, nwr: 25};
    vecs[4] = '{sym: 7'd5,   x: 100, y: 200, mode: 2, dup: 1'b0, lat: FULL_LAT, nwr: 140};
    vecs[5] = '{sym: 7'd127, x: 638, y: 0,   mode: 0, dup: 1'b0, lat: FULL_LAT, nwr: 28};
    vecs[6] = '{sym: 7'd1,   x: 0,   y: 460, mode: 0, dup: 1'b1, lat: FULL_LAT, nwr: 140};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.symbol = '0;
    bus.x = '0;
    bus.y = '0;
    repeat (3) step();
    chk("reset_ready", bus.ready, 1);
    chk("reset_valid", bus.fb_wr_valid, 0);
    chk("reset_x", bus.fb_wr_x, 0);
    chk("reset_y", bus.fb_wr_y, 0);
    chk("reset_data", bus.fb_wr_data, 0);
    chk("reset_font_addr", bus.font_addr, 0);
    rst = 1'b0;
    repeat (2) step();

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // asynchronous reset while a write is pending
    stall_mode = 3;
    bus.symbol = 7'd1;
    bus.x = 10'd0;
    bus.y = 9'd460;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    n = 0;
    while (!bus.fb_wr_valid && n < 50) begin
      step();
      n++;
    end
    chk("valid_before_reset", bus.fb_wr_valid, 1);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.fb_wr_valid, 0);
    chk("async_rst_ready", bus.ready, 1);
    chk("async_rst_font_addr", bus.font_addr, 0);
    #1 rst = 1'b0;
    hold_pending = 1'b0;
    exp_q.delete();
    stall_mode = 0;
    step();
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/symbol_drawer.md
# symbol_drawer

Responder side of the symbol-draw start/ready handshake issued by the graphics sequencer. On a one-cycle `start` pulse it latches a symbol code and a top-left pixel position, fetches the glyph row by row from an external synchronous font ROM, and emits scaled pixel writes toward the framebuffer writer over a valid/ready channel. It sits between the graphics sequencer and the framebuffer write port, alongside the fill drawer.

## Interface
- `SYMBOL_WIDTH`, 7, symbol code width
- `HOR_ACTIVE_PIXELS`, 640, visible width; `X_WIDTH = $clog2(HOR_ACTIVE_PIXELS)`
- `VER_ACTIVE_PIXELS`, 480, visible height; `Y_WIDTH = $clog2(VER_ACTIVE_PIXELS)`
- `GLYPH_COLS`, 5, font columns per glyph row
- `GLYPH_ROWS`, 7, font rows per glyph (≤ 8)
- `SCALE`, 2, pixel replication factor in x and y
- `clk`  in  1  clock, all logic on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  one-cycle request; sampled only in IDLE
- `ready`  out  1  high only in IDLE
- `symbol`  in  SYMBOL_WIDTH  code, latched on accepted `start`
- `x`  in  X_WIDTH  glyph left pixel, latched on `start`
- `y`  in  Y_WIDTH  glyph top pixel, latched on `start`
- `font_addr`  out  SYMBOL_WIDTH+3  `{symbol_q, row[2:0]}`
- `font_data`  in  GLYPH_COLS  row bitmap, MSB = leftmost column, valid one cycle after `font_addr`
- `fb_wr_valid`  out  1  pixel write request
- `fb_wr_ready`  in  1  framebuffer accepts write
- `fb_wr_x`  out  X_WIDTH  pixel x
- `fb_wr_y`  out  Y_WIDTH  pixel y
- `fb_wr_data`  out  1  pixel colour (1 = foreground)

## Operation
- States: IDLE, FETCH, LOAD, DRAW, FINISH.
- IDLE: `ready`=1. `start`=1 → latch `symbol`,`x`,`y`; clear row/sub-row/column/sub-column counters; next FETCH, or FINISH if `symbol`==0 (terminator: no writes).
- FETCH: `font_addr` presents current row; next LOAD.
- LOAD: capture `font_data` into row register; next DRAW.
- DRAW: one candidate pixel per step, order: sub-column (inner), column, sub-row, row (outer). Pixel = (`x_q + col*SCALE + sx`, `y_q + row*SCALE + sy`), sums truncated to X_WIDTH/Y_WIDTH.
  - Clipped pixel (truncated x ≥ HOR_ACTIVE_PIXELS or y ≥ VER_ACTIVE_PIXELS) or skipped pixel (see Configuration): `fb_wr_valid`=0, advance in one cycle.
  - Otherwise `fb_wr_valid`=1; hold x/y/data stable until `fb_wr_ready`=1, then advance.
  - Last pixel of last sub-row of a glyph row: next FETCH with row+1, or FINISH after row GLYPH_ROWS-1.
- FINISH: next IDLE.
- `start` outside IDLE is ignored; inputs `symbol`/`x`/`y` only sampled on accepted start.
- `rst` asserted in any state: immediately IDLE, all counters 0.

## Timing
- Reset values: `ready`=1, `fb_wr_valid`=0, `fb_wr_x`=0, `fb_wr_y`=0, `fb_wr_data`=0, `font_addr`=0.
- `ready` falls on the edge that samples `start`; initiator sees it low no later than one cycle after its pulse.
- Per glyph row with `fb_wr_ready` tied high: 2 + GLYPH_COLS·SCALE·SCALE cycles (22 default).
- Full glyph, no backpressure: `ready` low for GLYPH_ROWS·(2+GLYPH_COLS·SCALE²)+1 cycles (155 default), independent of bitmap and clipping.
- Symbol 0: `ready` low exactly 1 cycle.
- Each cycle `fb_wr_ready`=0 while `fb_wr_valid`=1 adds one cycle.
- `fb_wr_valid` never asserted outside DRAW; no combinational path from `fb_wr_ready` to `fb_wr_valid`.

## Configuration
- `SYMBOL_DRAWER_TRANSPARENT_EN` defined: only foreground bits (font bit 1) written, `fb_wr_data`=1 always; background pixels are skipped steps.
- Undefined: every unclipped pixel of the GLYPH_COLS·SCALE × GLYPH_ROWS·SCALE cell written, `fb_wr_data` = font bit (background overwritten with 0).

## Test plan
- ROM returns 5'b10001 for all rows of symbol 1; start x=0, y=460, `fb_wr_ready`=1 → first write (0,460,1), second (1,460,1); `ready` low 155 cycles; 56 writes with macro, 140 (56 with data 1) without.
- Symbol 0 start → `ready` low 1 cycle, zero writes, `font_addr` activity irrelevant.
- Same as first, `fb_wr_ready` toggled 50% → identical write sequence, x/y/data stable while stalled, latency grows by stall count.
- x=635, y=475, all-ones font, no macro → only pixels with x≤639, y≤479 written (25 writes), latency still 155.
- Second `start` pulse mid-glyph with different symbol/x → ignored; output identical to single-start run.
- `rst` pulsed mid-DRAW while `fb_wr_valid`=1 → `fb_wr_valid`=0 and `ready`=1 without clock edge; fresh start afterwards draws full glyph correctly.
